// File: rtl/io_fifo_port.sv
// Port-mapped I/O responder: a 4-port window that bridges CPU OUT/IN to a TX/RX stream pair
// through small circular FIFOs, with status, control and a display copy of the status word.
module io_fifo_port #(
    parameter int unsigned              p_data_width      = 16,
    parameter int unsigned              p_port_width      = 8,
    parameter logic [p_port_width-1:0]  p_base_port       = p_port_width'(8'h10),
    parameter int unsigned              p_fifo_depth_log2 = 2
) (
    input  logic                    i_w_clk,
    input  logic                    i_w_reset,
    input  logic                    i_w_io_oe,
    input  logic                    i_w_io_we,
    input  logic [p_port_width-1:0] i_w_io_port,
    input  logic [p_data_width-1:0] i_w_io_in,
    output logic [p_data_width-1:0] o_w_io_out,
    output logic [p_data_width-1:0] o_w_tx_data,
    output logic                    o_w_tx_valid,
    input  logic                    i_w_tx_ready,
    input  logic [p_data_width-1:0] i_w_rx_data,
    input  logic                    i_w_rx_valid,
    output logic                    o_w_rx_ready,
    output logic [p_data_width-1:0] o_w_disp_out
);

    localparam int unsigned aw    = p_fifo_depth_log2;
    localparam int unsigned cw    = p_fifo_depth_log2 + 1;
    localparam int unsigned depth = 1 << p_fifo_depth_log2;

    logic [p_data_width-1:0] tx_mem [depth];
    logic [p_data_width-1:0] rx_mem [depth];
    logic [aw-1:0]           tx_wr, tx_rd, rx_wr, rx_rd;
    logic [cw-1:0]           tx_cnt, rx_cnt;
    logic                    rx_underrun, tx_drop;
    logic [p_data_width-1:0] hold;
    logic                    prev_oe, prev_we;
    logic [p_port_width-1:0] prev_port;

    logic                    sel, rd_start, wr_start, rd_act, wr_act;
    logic [1:0]              offset;
    logic                    data_rd, data_wr, ctrl_wr;
    logic                    flush_tx, flush_rx, clr_flags;
    logic                    tx_push, tx_pop, rx_push, rx_pop;
    logic                    tx_empty, tx_full, rx_empty, rx_full;
    logic                    underrun_set, drop_set;
    logic [p_data_width-1:0] status, rd_val;

    // Window decode and access-start detection against last cycle's enable/port
    assign sel      = i_w_io_port[p_port_width-1:2] == p_base_port[p_port_width-1:2];
    assign offset   = i_w_io_port[1:0];
    assign rd_start = i_w_io_oe && (!prev_oe || prev_port != i_w_io_port);
    assign wr_start = i_w_io_we && (!prev_we || prev_port != i_w_io_port);
    assign rd_act   = rd_start && sel && !i_w_reset;
    assign wr_act   = wr_start && sel && !i_w_reset;

    assign data_rd   = rd_act && offset == 2'd0;
    assign data_wr   = wr_act && offset == 2'd0;
    assign ctrl_wr   = wr_act && offset == 2'd2;
    assign clr_flags = ctrl_wr && i_w_io_in[0];
    assign flush_tx  = ctrl_wr && i_w_io_in[1];
    assign flush_rx  = ctrl_wr && i_w_io_in[2];

    assign tx_empty = tx_cnt == '0;
    assign tx_full  = tx_cnt == cw'(depth);
    assign rx_empty = rx_cnt == '0;
    assign rx_full  = rx_cnt == cw'(depth);

    // Full/empty decisions all use the pre-edge counts; flush wins over traffic
    assign tx_push      = data_wr && !tx_full && !flush_tx;
    assign tx_pop       = o_w_tx_valid && i_w_tx_ready && !flush_tx;
    assign rx_push      = i_w_rx_valid && o_w_rx_ready && !flush_rx;
    assign rx_pop       = data_rd && !rx_empty && !flush_rx;
    assign underrun_set = data_rd && rx_empty;
    assign drop_set     = data_wr && tx_full && !flush_tx;

    assign status = p_data_width'({4'(tx_cnt), 4'(rx_cnt), 2'b00, tx_drop, rx_underrun,
                                   tx_full, tx_empty, rx_full, rx_empty});

    always_comb begin
        rd_val = '0;
        case (offset)
            2'd0:    if (!rx_empty) rd_val = rx_mem[rx_rd];
            2'd1:    rd_val = status;
            default: rd_val = '0;
        endcase
    end

    // Start cycle shows live data; later cycles of the same access replay the captured word
    assign o_w_io_out   = (i_w_reset || !i_w_io_oe || !sel) ? '0 : (rd_start ? rd_val : hold);
    assign o_w_tx_data  = tx_mem[tx_rd];
    assign o_w_tx_valid = !i_w_reset && !tx_empty;
    assign o_w_rx_ready = !i_w_reset && !rx_full;
    assign o_w_disp_out = status;

    always_ff @(posedge i_w_clk) begin
        if (tx_push) tx_mem[tx_wr] <= i_w_io_in;
        if (rx_push) rx_mem[rx_wr] <= i_w_rx_data;
    end

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            tx_wr       <= '0;
            tx_rd       <= '0;
            tx_cnt      <= '0;
            rx_wr       <= '0;
            rx_rd       <= '0;
            rx_cnt      <= '0;
            rx_underrun <= 1'b0;
            tx_drop     <= 1'b0;
            hold        <= '0;
            prev_oe     <= 1'b0;
            prev_we     <= 1'b0;
            prev_port   <= '0;
        end else begin
            prev_oe   <= i_w_io_oe;
            prev_we   <= i_w_io_we;
            prev_port <= i_w_io_port;
            if (rd_act) hold <= rd_val;

            if (flush_tx) begin
                tx_wr  <= '0;
                tx_rd  <= '0;
                tx_cnt <= '0;
            end else begin
                if (tx_push) tx_wr <= tx_wr + aw'(1);
                if (tx_pop)  tx_rd <= tx_rd + aw'(1);
                tx_cnt <= tx_cnt + cw'(tx_push) - cw'(tx_pop);
            end

            if (flush_rx) begin
                rx_wr  <= '0;
                rx_rd  <= '0;
                rx_cnt <= '0;
            end else begin
                if (rx_push) rx_wr <= rx_wr + aw'(1);
                if (rx_pop)  rx_rd <= rx_rd + aw'(1);
                rx_cnt <= rx_cnt + cw'(rx_push) - cw'(rx_pop);
            end

            // A new event in the same cycle outranks a clear request
            rx_underrun <= underrun_set || (rx_underrun && !clr_flags);
            tx_drop     <= drop_set || (tx_drop && !clr_flags);
        end
    end

endmodule

// File: tb/tb_io_fifo_port.sv
// Bench for io_fifo_port: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the port window and both FIFOs.
module tb_io_fifo_port;

    logic        clk, rst, oe, we, tx_valid, tx_ready, rx_valid, rx_ready;
    logic [7:0]  port;
    logic [15:0] din, dout, tx_data, rx_data, disp;

    int checks = 0;
    int failures = 0;

    io_fifo_port dut (
        .i_w_clk      (clk),
        .i_w_reset    (rst),
        .i_w_io_oe    (oe),
        .i_w_io_we    (we),
        .i_w_io_port  (port),
        .i_w_io_in    (din),
        .o_w_io_out   (dout),
        .o_w_tx_data  (tx_data),
        .o_w_tx_valid (tx_valid),
        .i_w_tx_ready (tx_ready),
        .i_w_rx_data  (rx_data),
        .i_w_rx_valid (rx_valid),
        .o_w_rx_ready (rx_ready),
        .o_w_disp_out (disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    bit          und, drp, m_prev_oe, m_prev_we, rx_acc;
    logic [7:0]  m_prev_port;
    logic [15:0] m_hold;

    function automatic logic [15:0] m_status();
        int t = txq.size();
        int r = rxq.size();
        return {4'(t), 4'(r), 2'b00, drp, und, t == 4, t == 0, r == 4, r == 0};
    endfunction

    function automatic logic [15:0] exp_out();
        if (rst || !oe || port[7:2] != 6'h04) return 16'h0;
        if (!m_prev_oe || m_prev_port != port) begin
            case (port[1:0])
                2'd0:    return (rxq.size() > 0) ? rxq[0] : 16'h0;
                2'd1:    return m_status();
                default: return 16'h0;
            endcase
        end
        return m_hold;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to the model using the pre-edge inputs and state
    task automatic model_edge();
        bit sel, srd, swr, ftx, frx, clr, cpu_push, rd_data, tx_full_pre, rx_push, tx_pop;
        logic [15:0] o;
        if (rst) begin
            txq.delete(); rxq.delete();
            und = 0; drp = 0; m_prev_oe = 0; m_prev_we = 0; m_prev_port = 8'h0; m_hold = 16'h0;
            rx_acc = 0;
            return;
        end
        o        = exp_out();
        sel      = port[7:2] == 6'h04;
        srd      = oe && (!m_prev_oe || m_prev_port != port);
        swr      = we && (!m_prev_we || m_prev_port != port);
        ftx      = swr && sel && port[1:0] == 2'd2 && din[1];
        frx      = swr && sel && port[1:0] == 2'd2 && din[2];
        clr      = swr && sel && port[1:0] == 2'd2 && din[0];
        cpu_push = swr && sel && port[1:0] == 2'd0;
        rd_data  = srd && sel && port[1:0] == 2'd0;
        tx_full_pre = txq.size() == 4;
        tx_pop   = txq.size() > 0 && tx_ready;
        rx_push  = rx_valid && rxq.size() < 4;
        rx_acc   = rx_push;
        if (srd && sel) m_hold = o;
        if (rd_data && rxq.size() == 0) und = 1;
        else if (clr) und = 0;
        if (cpu_push && tx_full_pre && !ftx) drp = 1;
        else if (clr) drp = 0;
        if (ftx) txq.delete();
        else begin
            if (tx_pop) void'(txq.pop_front());
            if (cpu_push && !tx_full_pre) txq.push_back(din);
        end
        if (frx) rxq.delete();
        else begin
            if (rd_data && rxq.size() > 0) void'(rxq.pop_front());
            if (rx_push) rxq.push_back(rx_data);
        end
        m_prev_oe = oe; m_prev_we = we; m_prev_port = port;
    endtask

    task automatic settle();
        #2;
        chk("io_out", dout, exp_out());
        chk("tx_valid", 16'(tx_valid), 16'(!rst && txq.size() > 0));
        if (!rst && txq.size() > 0) chk("tx_data", tx_data, txq[0]);
        chk("rx_ready", 16'(rx_ready), 16'(!rst && rxq.size() < 4));
        chk("disp", disp, m_status());
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic set_cpu(input bit o, input bit w, input logic [7:0] p, input logic [15:0] d);
        oe = o; we = w; port = p; din = d;
    endtask

    initial begin
        rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 16'h0;
        set_cpu(0, 0, 8'h00, 16'h0);
        txq.delete(); rxq.delete();
        und = 0; drp = 0; m_prev_oe = 0; m_prev_we = 0; m_prev_port = 8'h0; m_hold = 16'h0; rx_acc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();
        rst = 1'b0;

        // Reset state through the STATUS port
        set_cpu(1, 0, 8'h11, 16'h0);
        settle();
        chk("rst_status", dout, 16'h0005);
        chk("rst_rx_ready", 16'(rx_ready), 16'd1);
        chk("rst_tx_valid", 16'(tx_valid), 16'd0);
        tick();
        set_cpu(0, 0, 8'h00, 16'h0); step();

        // Fill TX past full with the sink stalled, then drain in order
        for (int i = 0; i < 5; i++) begin
            set_cpu(0, 1, 8'h10, 16'hA001 + 16'(i)); step();
            set_cpu(0, 0, 8'h10, 16'h0); step();
        end
        set_cpu(1, 0, 8'h11, 16'h0);
        settle();
        chk("status_tx_full", dout, 16'h4029);
        tick();
        set_cpu(0, 0, 8'h00, 16'h0);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("drain_valid", 16'(tx_valid), 16'd1);
            chk("drain_data", tx_data, 16'hA001 + 16'(i));
            tick();
        end
        settle();
        chk("drained_valid", 16'(tx_valid), 16'd0);
        tick();
        tx_ready = 1'b0;

        // Two source words, a held read, a second read and an underrun
        rx_valid = 1'b1; rx_data = 16'h1111; step();
        rx_data = 16'h2222; step();
        rx_valid = 1'b0;
        set_cpu(1, 0, 8'h10, 16'h0);
        repeat (3) begin
            settle();
            chk("held_read", dout, 16'h1111);
            tick();
        end
        set_cpu(0, 0, 8'h00, 16'h0);
        settle();
        chk("single_pop", 16'(disp[11:8]), 16'd1);
        tick();
        set_cpu(1, 0, 8'h10, 16'h0); settle(); chk("second_read", dout, 16'h2222); tick();
        set_cpu(0, 0, 8'h00, 16'h0); step();
        set_cpu(1, 0, 8'h10, 16'h0); settle(); chk("empty_read", dout, 16'h0000); tick();
        set_cpu(0, 0, 8'h00, 16'h0);
        settle();
        chk("underrun_flag", 16'(disp[4]), 16'd1);
        tick();

        // RX full while the CPU pops on the same edge
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 16'h3000 + 16'(i); step();
        end
        rx_data = 16'h3004;
        set_cpu(1, 0, 8'h10, 16'h0);
        settle();
        chk("full_rx_ready", 16'(rx_ready), 16'd0);
        chk("full_pop_data", dout, 16'h3000);
        tick();
        set_cpu(0, 0, 8'h00, 16'h0);
        settle();
        chk("rx_count_3", 16'(disp[11:8]), 16'd3);
        chk("rx_ready_again", 16'(rx_ready), 16'd1);
        tick();
        rx_valid = 1'b0;
        settle();
        chk("rx_count_4", 16'(disp[11:8]), 16'd4);
        tick();
        set_cpu(0, 1, 8'h12, 16'h0004); step();
        set_cpu(0, 0, 8'h00, 16'h0);
        settle();
        chk("rx_flushed", 16'(disp[11:8]), 16'd0);
        tick();

        // Control write: flush TX and clear both sticky flags
        for (int i = 0; i < 3; i++) begin
            set_cpu(0, 1, 8'h10, 16'hB000 + 16'(i)); step();
            set_cpu(0, 0, 8'h10, 16'h0); step();
        end
        settle();
        chk("flags_before", 16'(disp[5:4]), 16'd3);
        chk("tx_count_3", 16'(disp[15:12]), 16'd3);
        tick();
        set_cpu(0, 1, 8'h12, 16'h0003); step();
        set_cpu(0, 0, 8'h00, 16'h0);
        settle();
        chk("tx_flushed", 16'(disp[15:12]), 16'd0);
        chk("flags_cleared", 16'(disp[5:4]), 16'd0);
        chk("flush_tx_valid", 16'(tx_valid), 16'd0);
        tick();

        // Reset landing on a held DATA write
        set_cpu(0, 1, 8'h10, 16'hC0DE); step();
        set_cpu(0, 0, 8'h10, 16'h0); step();
        set_cpu(0, 1, 8'h10, 16'hBEEF);
        rst = 1'b1; step(); step();
        rst = 1'b0;
        set_cpu(0, 0, 8'h10, 16'h0);
        settle();
        chk("post_rst_tx_valid", 16'(tx_valid), 16'd0);
        chk("post_rst_status", disp, 16'h0005);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if (rx_acc || !rx_valid) begin
                rx_valid = ($urandom % 2) == 0;
                rx_data  = 16'($urandom);
            end
            tx_ready = ($urandom % 2) == 0;
            rst      = ($urandom % 80) == 0;
            if (($urandom % 2) == 0) begin
                oe   = ($urandom % 3) == 0;
                we   = ($urandom % 3) == 0;
                port = (($urandom % 8) == 0) ? 8'($urandom) : 8'h10 + 8'($urandom % 4);
                din  = 16'($urandom);
                if (($urandom % 4) != 0) din[2:1] = 2'b00;
            end
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
